// File: rtl/byte_assembler_pkg.sv
// Shared widths, fill-state type and lane placement helper for the byte assembler.
package byte_assembler_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    FILL3 = 2'd3
  } fill_cnt_t;

  function automatic fill_cnt_t next_fill(input fill_cnt_t cur);
    fill_cnt_t nxt;
    nxt = FILL0;
    case (cur)
      FILL0:   nxt = FILL1;
      FILL1:   nxt = FILL2;
      FILL2:   nxt = FILL3;
      default: nxt = FILL0;
    endcase
    return nxt;
  endfunction

  // Write byte number idx (acceptance order) into its lane of word.
  function automatic logic [WORD_W-1:0] place_byte(
    input logic [WORD_W-1:0] word,
    input logic [BYTE_W-1:0] b,
    input logic [1:0]        idx,
    input bit                msb_first
  );
    logic [WORD_W-1:0] w;
    logic [1:0]        lane;
    w    = word;
    lane = msb_first ? 2'(BYTES_PER_WORD - 1 - 32'(idx)) : idx;
    w[BYTE_W*32'(lane) +: BYTE_W] = b;
    return w;
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Packs a stream of bytes into 32-bit words with valid/ready on both sides.
module byte_assembler
  import byte_assembler_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_word,
  input  logic              out_ready,
  output logic [1:0]        byte_cnt
);

  fill_cnt_t         state;
  logic [WORD_W-1:0] staging;
  logic              accept;
  logic              xfer;
  logic              complete;

  // Only the fourth byte can stall, and only while the held word is not leaving.
  assign in_ready = !((state == FILL3) && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign complete = accept && (state == FILL3);
  assign byte_cnt = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL0;
      staging   <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        state <= next_fill(state);
        if (state != FILL3) begin
          staging <= place_byte(staging, in_byte, state, MSB_FIRST);
        end
      end
      // A completion in the same cycle as a transfer replaces the word without a bubble.
      if (complete) begin
        out_word  <= place_byte(staging, in_byte, FILL3, MSB_FIRST);
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_assembler.sv
// Self-checking bench for byte_assembler: both byte orders, backpressure, reset and random round trip.
module tb_byte_assembler;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        out_ready;
  logic        ready_cmd;
  logic        rnd_en;
  logic        in_ready,  l_in_ready;
  logic        out_valid, l_out_valid;
  logic [31:0] out_word,  l_out_word;
  logic [1:0]  byte_cnt,  l_byte_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q_msb[$];
  logic [31:0] q_lsb[$];
  logic [31:0] mon_m, mon_l;

  typedef struct packed {
    logic [31:0] bytes_in;  // byte 0 in [31:24] ... byte 3 in [7:0]
    logic [31:0] exp_msb;
    logic [31:0] exp_lsb;
  } vec_t;
  vec_t vecs [4];

  byte_assembler #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .out_valid(out_valid), .out_word(out_word),
    .out_ready(out_ready), .byte_cnt(byte_cnt)
  );

  byte_assembler #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(l_in_ready), .out_valid(l_out_valid), .out_word(l_out_word),
    .out_ready(out_ready), .byte_cnt(l_byte_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // out_ready changes only shortly after a rising edge, so it is stable at the sampling edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rnd_en ? 1'($urandom_range(0, 1)) : ready_cmd;
    end
  end

  // Scoreboard: every word transfer pops and compares the oldest expected word.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q_msb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %h with no word expected", out_word);
      end else begin
        mon_m = q_msb.pop_front();
        mon_l = q_lsb.pop_front();
        check("word_msb", out_word, mon_m);
        check("word_lsb", l_out_word, mon_l);
        check("lsb_valid", 32'(l_out_valid), 32'd1);
      end
    end
  end

  task automatic push_word(input logic [31:0] m, input logic [31:0] l);
    q_msb.push_back(m);
    q_lsb.push_back(l);
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the byte.
  task automatic send_byte(input logic [7:0] b, input int exp_cnt);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    if (exp_cnt >= 0) begin
      check("byte_cnt_msb", 32'(byte_cnt), 32'(exp_cnt));
      check("byte_cnt_lsb", 32'(l_byte_cnt), 32'(exp_cnt));
    end
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: byte %h never accepted", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] src;
    int          n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    ready_cmd = 1'b1;
    rnd_en    = 1'b0;

    vecs[0] = '{bytes_in: 32'h12345678, exp_msb: 32'h12345678, exp_lsb: 32'h78563412};
    vecs[1] = '{bytes_in: 32'hDEADBEEF, exp_msb: 32'hDEADBEEF, exp_lsb: 32'hEFBEADDE};
    vecs[2] = '{bytes_in: 32'h00000001, exp_msb: 32'h00000001, exp_lsb: 32'h01000000};
    vecs[3] = '{bytes_in: 32'hFF00FF00, exp_msb: 32'hFF00FF00, exp_lsb: 32'h00FF00FF};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", out_word, 32'h0);
    check("rst_out_word_lsb", l_out_word, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Table: back-to-back bytes with out_ready=1; word valid one cycle after the 4th accept, for one cycle.
    @(posedge clk);
    #1;
    for (int v = 0; v < 4; v++) begin
      push_word(vecs[v].exp_msb, vecs[v].exp_lsb);
      for (int k = 0; k < 4; k++) begin
        send_byte(vecs[v].bytes_in[31-8*k -: 8], k);
      end
      @(negedge clk);
      check("valid_latency", 32'(out_valid), 32'd1);
      @(negedge clk);
      check("valid_one_cycle", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end

    // Backpressure: held word blocks only the 4th byte of the next word.
    ready_cmd = 1'b0;
    push_word(32'hAABBCCDD, 32'hDDCCBBAA);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 2);
    send_byte(8'hDD, 3);
    push_word(32'h11223344, 32'h44332211);
    send_byte(8'h11, 0);
    send_byte(8'h22, 1);
    send_byte(8'h33, 2);
    in_valid = 1'b1;
    in_byte  = 8'h44;
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_in_ready_lsb", 32'(l_in_ready), 32'd0);
    check("bp_byte_cnt", 32'(byte_cnt), 32'd3);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_word_held", out_word, 32'hAABBCCDD);
    @(posedge clk);
    #1;
    check("bp_word_stable", out_word, 32'hAABBCCDD);
    ready_cmd = 1'b1;
    @(negedge clk);
    check("bp_in_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    ready_cmd = 1'b0;
    @(negedge clk);
    check("bp_no_bubble", 32'(out_valid), 32'd1);
    check("bp_new_word", out_word, 32'h11223344);
    check("bp_cnt_wrap", 32'(byte_cnt), 32'd0);
    @(posedge clk);
    #1;
    ready_cmd = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Reset mid-word, with a byte offered during reset that must be ignored.
    @(posedge clk);
    #1;
    send_byte(8'h01, 0);
    send_byte(8'h02, 1);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h03;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_byte_cnt", 32'(byte_cnt), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    push_word(32'hA0B0C0D0, 32'hD0C0B0A0);
    send_byte(8'hA0, 0);
    send_byte(8'hB0, 1);
    send_byte(8'hC0, 2);
    send_byte(8'hD0, 3);
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd1);

    // Random round trip: words split MSB byte first, random gaps and random out_ready.
    @(posedge clk);
    #1;
    rnd_en = 1'b1;
    for (int w = 0; w < 40; w++) begin
      src = $urandom;
      push_word(src, {src[7:0], src[15:8], src[23:16], src[31:24]});
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send_byte(src[31-8*k -: 8], -1);
      end
    end
    ready_cmd = 1'b1;
    rnd_en    = 1'b0;
    n = 0;
    while (q_msb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rand_all_drained", 32'(q_msb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
